// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one request in flight, IDLE -> ACCESS -> RESP,
// byte-enabled stores, sign/zero-extended loads and misalign/range/funct3 errors.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0020_0000,
    parameter int unsigned DEPTH_WORDS = 81920
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);
    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One past the last byte, kept at 33 bits so the limit cannot wrap.
    localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            out_of_range;
    logic            misaligned;
    logic            bad_funct3;
    logic            access_err;
    logic [IdxW-1:0] idx;
    logic [1:0]      lane;
    logic [3:0]      byte_en;
    logic [31:0]     wdata_sh;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     rdata_ext;

    assign accept = (state_q == StIdle) && bus.req_valid;
    assign lane   = addr_q[1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (bus.rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        out_of_range = ({1'b0, addr_q} < {1'b0, BASE_ADDR}) || ({1'b0, addr_q} >= LimitAddr);
        misaligned   = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                       ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
        bad_funct3   = (funct3_q[1:0] == 2'b11) || (we_q ? funct3_q[2] : (funct3_q == 3'b110));
        access_err   = out_of_range || misaligned || bad_funct3;
        idx          = IdxW'((addr_q - BASE_ADDR) >> 2);
        case (funct3_q[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
        wdata_sh = wdata_q << {lane, 3'b000};
    end

    always_comb begin
        byte_v = 8'(word_q >> {lane, 3'b000});
        half_v = 16'(word_q >> {lane[1], 4'b0000});
        case (funct3_q)
            3'b000:  rdata_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  rdata_ext = {{16{half_v[15]}}, half_v};
            3'b010:  rdata_ext = word_q;
            3'b100:  rdata_ext = {24'b0, byte_v};
            3'b101:  rdata_ext = {16'b0, half_v};
            default: rdata_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (state_q == StAccess) begin
                err_q <= access_err;
                // Stores and errors leave zero here so they respond with rdata = 0.
                word_q <= (!we_q && !access_err) ? mem[idx] : '0;
            end
        end
    end

    // Array has no reset; a reset coinciding with ACCESS cancels the write.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StAccess) && we_q && !access_err) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rdata_ext;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random loads/stores checked
// against a byte-addressed reference memory.
module tb_dmem_responder;
    localparam logic [31:0] BASE  = 32'h0020_0000;
    localparam int unsigned DEPTH = 81920;
    localparam logic [31:0] END32 = BASE + 32'(4 * DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;
    bit [7:0]    mem_m [longint unsigned];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as individual bytes, rules taken straight from the ISA behaviour.
    function automatic void model(input bit we, input bit [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic err);
        longint unsigned la = longint'(a);
        int n;
        logic [31:0] raw;
        n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * longint'(DEPTH));
        if (f3[1:0] == 2'b11) err = 1'b1;
        if (we && f3[2]) err = 1'b1;
        if (!we && f3 == 3'b110) err = 1'b1;
        if (n == 2 && a[0]) err = 1'b1;
        if (n == 4 && a[1:0] != 2'b00) err = 1'b1;
        rd = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[la + longint'(i)] = wd[8*i +: 8];
            return;
        end
        raw = '0;
        for (int i = 0; i < n; i++)
            raw[8*i +: 8] = mem_m.exists(la + longint'(i)) ? mem_m[la + longint'(i)] : 8'h00;
        case (f3)
            3'b000:  rd = {{24{raw[7]}}, raw[7:0]};
            3'b001:  rd = {{16{raw[15]}}, raw[15:0]};
            3'b010:  rd = raw;
            3'b100:  rd = {24'b0, raw[7:0]};
            default: rd = {16'b0, raw[15:0]};
        endcase
    endfunction

    // One full transaction; junk is driven on req_* after the accept edge.
    task automatic xact(input string tag, input bit we, input bit [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] obs_rd, output logic obs_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        model(we, f3, a, wd, exp_rd, exp_err);
        @(negedge clk);
        check({tag, ".idle"}, 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = BASE + 32'($urandom_range(0, 63));
        bus.req_wdata  = $urandom;
        @(negedge clk);
        check({tag, ".access"}, 32'({bus.req_ready, bus.rsp_valid}), 32'b00);
        @(negedge clk);
        check({tag, ".rsp_valid"}, 32'({bus.req_ready, bus.rsp_valid}), 32'b01);
        obs_rd  = bus.rsp_rdata;
        obs_err = bus.rsp_err;
        check({tag, ".rdata"}, obs_rd, exp_rd);
        check({tag, ".err"}, 32'(obs_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold"}, {bus.rsp_rdata[29:0], bus.rsp_valid, bus.req_ready},
                  {obs_rd[29:0], 2'b10});
            check({tag, ".hold_hi"}, 32'({bus.rsp_rdata[31:30], bus.rsp_err}),
                  32'({obs_rd[31:30], obs_err}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] a;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);

        xact("sw0", 1'b1, 3'b010, BASE, 32'hDEAD_BEEF, 0, rd, er);
        check("sw0.c", {rd[30:0], er}, 32'd0);
        xact("lw0", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
        check("lw0.c", rd, 32'hDEAD_BEEF);

        xact("sb1", 1'b1, 3'b000, BASE + 1, 32'h80, 0, rd, er);
        xact("lb1", 1'b0, 3'b000, BASE + 1, 32'h0, 0, rd, er);
        check("lb1.c", rd, 32'hFFFF_FF80);
        xact("lbu1", 1'b0, 3'b100, BASE + 1, 32'h0, 0, rd, er);
        check("lbu1.c", rd, 32'h0000_0080);
        xact("lhu2", 1'b0, 3'b101, BASE + 2, 32'h0, 0, rd, er);
        check("lhu2.c", rd, 32'h0000_DEAD);
        xact("lw1", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
        check("lw1.c", rd, 32'hDEAD_80EF);

        xact("lw_mis", 1'b0, 3'b010, BASE + 2, 32'h0, 0, rd, er);
        check("lw_mis.c", {rd[30:0], er}, 32'd1);
        xact("sh_mis", 1'b1, 3'b001, BASE + 3, 32'hFFFF, 0, rd, er);
        check("sh_mis.c", {rd[30:0], er}, 32'd1);
        xact("lw_low", 1'b0, 3'b010, BASE - 4, 32'h0, 0, rd, er);
        check("lw_low.c", {rd[30:0], er}, 32'd1);
        xact("lw_hi", 1'b0, 3'b010, END32, 32'h0, 0, rd, er);
        check("lw_hi.c", {rd[30:0], er}, 32'd1);
        xact("lw2", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
        check("lw2.c", rd, 32'hDEAD_80EF);

        xact("lw_hold", 1'b0, 3'b010, BASE, 32'h0, 5, rd, er);

        // Reset during ACCESS cancels the store.
        xact("sw10", 1'b1, 3'b010, BASE + 32'h10, 32'hCAFE_F00D, 0, rd, er);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = BASE + 32'h10;
        bus.req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_acc.state", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
        end
        xact("lw10", 1'b0, 3'b010, BASE + 32'h10, 32'h0, 0, rd, er);
        check("lw10.c", rd, 32'hCAFE_F00D);

        // Reset during RESP drops the response.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = BASE + 32'h10;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp.pre", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rsp.state", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err}), 32'b100);
        check("rst_rsp.rdata", bus.rsp_rdata, 32'd0);

        for (int w = 0; w < 16; w++)
            xact("init", 1'b1, 3'b010, BASE + 32'(4 * w), $urandom, 0, rd, er);
        xact("init_e0", 1'b1, 3'b010, END32 - 8, $urandom, 0, rd, er);
        xact("init_e1", 1'b1, 3'b010, END32 - 4, $urandom, 0, rd, er);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                7:       a = END32 - 8 + 32'($urandom_range(0, 7));
                8:       a = BASE - 8 + 32'($urandom_range(0, 7));
                9:       a = ($urandom_range(0, 1) == 0) ? END32 + 32'($urandom_range(0, 7))
                                                         : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            xact("rnd", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                 int'($urandom_range(0, 2)), rd, er);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
